// File: rtl/alu_mult_seq.sv
// ---------------------------------------------------------------------------
// alu_mult_seq
//   Iterative 16x16 shift-add multiplier sequencer. It drives an external
//   combinational 16-bit ALU (always configured for A+B) and registers the
//   ALU result back into its accumulator once per cycle. After the run it
//   presents the low 16 bits of a*b on `result`.
//
//   Optional feature: define MULT_EARLY_EXIT_EN to leave RUN as soon as the
//   remaining multiplier is zero. The result is the same as in the default
//   build; only the latency changes.
//
// Ports
//   clk      in   1  clock, rising edge
//   rst      in   1  asynchronous active-high reset
//   start    in   1  request, sampled only in IDLE or DONE
//   a, b     in   N  multiplicand / multiplier, captured on acceptance
//   busy     out  1  high while in RUN
//   done     out  1  high for exactly one cycle (DONE state)
//   result   out  N  low N bits of a*b, held until next acceptance
//   aluA     out  N  ALU operand A (accumulator)
//   aluB     out  N  ALU operand B (multiplicand or zero)
//   aluOp    out  4  ALU opcode, constant OP_ADD
//   aluCin, aluInvA, aluInvB, aluSign  out 1  ALU controls, constant 0
//   aluOut   in   N  ALU result
// ---------------------------------------------------------------------------
module alu_mult_seq #(
  parameter int          N      = 16,
  parameter logic [3:0]  OP_ADD = 4'b0100
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result,
  output logic [N-1:0] aluA,
  output logic [N-1:0] aluB,
  output logic [3:0]   aluOp,
  output logic         aluCin,
  output logic         aluInvA,
  output logic         aluInvB,
  output logic         aluSign,
  input  logic [N-1:0] aluOut
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  state_e       state_q, state_d;
  logic [N-1:0] acc_q, acc_d;
  logic [N-1:0] mcand_q, mcand_d;
  logic [N-1:0] mplier_q, mplier_d;
  logic [3:0]   cnt_q, cnt_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;

  // Next-state and datapath update for the IDLE/RUN/DONE sequencer.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          acc_d    = {N{1'b0}};
          mcand_d  = a;
          mplier_d = b;
          cnt_d    = 4'd0;
          state_d  = ST_RUN;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_RUN: begin
`ifdef MULT_EARLY_EXIT_EN
        // No set multiplier bits remain: the accumulator is already final.
        if (mplier_q == {N{1'b0}}) begin
          state_d = ST_DONE;
        end else begin
          acc_d    = aluOut;
          mcand_d  = {mcand_q[N-2:0], 1'b0};
          mplier_d = {1'b0, mplier_q[N-1:1]};
          cnt_d    = cnt_q + 4'd1;
          if (cnt_q == 4'd15) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_RUN;
          end
        end
`else
        acc_d    = aluOut;
        mcand_d  = {mcand_q[N-2:0], 1'b0};
        mplier_d = {1'b0, mplier_q[N-1:1]};
        cnt_d    = cnt_q + 4'd1;
        if (cnt_q == 4'd15) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_RUN;
        end
`endif
      end
      ST_DONE: begin
        if (start) begin
          acc_d    = {N{1'b0}};
          mcand_d  = a;
          mplier_d = b;
          cnt_d    = 4'd0;
          state_d  = ST_RUN;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      default: begin
        // Unreachable encoding: recover to a clean idle.
        acc_d    = {N{1'b0}};
        mcand_d  = {N{1'b0}};
        mplier_d = {N{1'b0}};
        cnt_d    = 4'd0;
        state_d  = ST_IDLE;
      end
    endcase
    // Status flags are registered alongside the state so they are glitch-free.
    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  // State, datapath and status registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      acc_q    <= {N{1'b0}};
      mcand_q  <= {N{1'b0}};
      mplier_q <= {N{1'b0}};
      cnt_q    <= 4'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign result  = acc_q;

  // The ALU adds the multiplicand only when the current multiplier LSB is set.
  assign aluA    = acc_q;
  assign aluB    = mplier_q[0] ? mcand_q : {N{1'b0}};
  assign aluOp   = OP_ADD;
  assign aluCin  = 1'b0;
  assign aluInvA = 1'b0;
  assign aluInvB = 1'b0;
  assign aluSign = 1'b0;

endmodule

// File: tb/tb_alu_mult_seq.sv
// Testbench for alu_mult_seq: a behavioural ALU closes the loop, a
// transaction-level model predicts busy/done/result every cycle, and
// directed vectors pin results and latencies with literal values.
module tb_alu_mult_seq;

  localparam logic [3:0] OP_ADD = 4'b0100;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] a_in;
  logic [15:0] b_in;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [3:0]  alu_op;
  logic        alu_cin;
  logic        alu_inv_a;
  logic        alu_inv_b;
  logic        alu_sign;
  logic [15:0] alu_out;

  int n_vec  = 0;
  int n_fail = 0;

  alu_mult_seq #(.N(16), .OP_ADD(OP_ADD)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a_in),
    .b       (b_in),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .aluA    (alu_a),
    .aluB    (alu_b),
    .aluOp   (alu_op),
    .aluCin  (alu_cin),
    .aluInvA (alu_inv_a),
    .aluInvB (alu_inv_b),
    .aluSign (alu_sign),
    .aluOut  (alu_out)
  );

  // Behavioural 16-bit ALU (only the add opcode matters here).
  logic [15:0] op_a_s;
  logic [15:0] op_b_s;
  assign op_a_s  = alu_inv_a ? ~alu_a : alu_a;
  assign op_b_s  = alu_inv_b ? ~alu_b : alu_b;
  assign alu_out = (alu_op == OP_ADD) ? (op_a_s + op_b_s + {15'd0, alu_cin}) : 16'h0000;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", name, act, exp, $time);
    end
  endtask

  // Cycles from acceptance to done, derived from the multiplier's value.
  function automatic int exp_lat(input logic [15:0] bv);
`ifdef MULT_EARLY_EXIT_EN
    int hb;
    hb = -1;
    for (int i = 0; i < 16; i++) if (bv[i]) hb = i;
    if (hb < 0) return 1;
    return (hb + 2 > 16) ? 16 : hb + 2;
`else
    return 16;
`endif
  endfunction

  // Transaction-level model: an accepted request finishes exp_lat cycles later.
  int          m_left;
  logic        m_done;
  logic        m_valid;
  logic [15:0] m_res;
  logic [15:0] m_pend;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_left  <= 0;
      m_done  <= 1'b0;
      m_valid <= 1'b1;
      m_res   <= 16'h0000;
      m_pend  <= 16'h0000;
    end else if (m_left == 0 && start) begin
      m_left  <= exp_lat(b_in);
      m_pend  <= 16'((32'(a_in) * 32'(b_in)) & 32'h0000FFFF);
      m_valid <= 1'b0;
      m_done  <= 1'b0;
    end else if (m_left > 0) begin
      if (m_left == 1) begin
        m_done  <= 1'b1;
        m_res   <= m_pend;
        m_valid <= 1'b1;
      end
      m_left <= m_left - 1;
    end else begin
      m_done <= 1'b0;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("busy", {15'd0, busy}, {15'd0, (m_left != 0)});
    check("done", {15'd0, done}, {15'd0, m_done});
    if (m_valid) check("result", result, m_res);
    check("aluOp", {12'd0, alu_op}, {12'd0, OP_ADD});
    check("aluCtl", {12'd0, alu_cin, alu_inv_a, alu_inv_b, alu_sign}, 16'h0000);
  end

  // Accept one request, wait (bounded) for done, check latency/busy/result.
  task automatic run_mult(input string name, input logic [15:0] av, input logic [15:0] bv,
                          input logic [15:0] exp_res, input int exp_cycles);
    int cycles;
    int busy_n;
    start = 1'b1; a_in = av; b_in = bv;
    @(negedge clk);
    start = 1'b0; a_in = 16'hDEAD; b_in = 16'hBEEF;
    cycles = 0;
    busy_n = busy ? 1 : 0;
    while (!done && cycles < 40) begin
      @(negedge clk);
      cycles++;
      if (busy) busy_n++;
    end
    check({name, "_lat"}, 16'(cycles), 16'(exp_cycles));
    check({name, "_busy"}, 16'(busy_n), 16'(exp_cycles));
    check({name, "_res"}, result, exp_res);
    @(negedge clk);
  endtask

  int cyc;
  int pulse_at;

  initial begin
    rst = 1'b1; start = 1'b0; a_in = 16'h0000; b_in = 16'h0000;
    #12;
    check("rst_busy", {15'd0, busy}, 16'h0000);
    check("rst_result", result, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run_mult("3x5", 16'h0003, 16'h0005, 16'h000F, exp_lat(16'h0005));
    run_mult("ffffxffff", 16'hFFFF, 16'hFFFF, 16'h0001, 16);
    run_mult("8000x2", 16'h8000, 16'h0002, 16'h0000, exp_lat(16'h0002));
`ifdef MULT_EARLY_EXIT_EN
    run_mult("1234x3", 16'h1234, 16'h0003, 16'h369C, 3);
    run_mult("1234x0", 16'h1234, 16'h0000, 16'h0000, 1);
`else
    run_mult("1234x3", 16'h1234, 16'h0003, 16'h369C, 16);
    run_mult("1234x0", 16'h1234, 16'h0000, 16'h0000, 16);
`endif

    // Start during RUN is ignored; then a start held in DONE restarts.
`ifdef MULT_EARLY_EXIT_EN
    pulse_at = 2;
`else
    pulse_at = 4;
`endif
    start = 1'b1; a_in = 16'd7; b_in = 16'd6;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!done && cyc < 40) begin
      if (cyc == pulse_at) begin
        start = 1'b1; a_in = 16'd1; b_in = 16'd1;
        @(negedge clk);
        start = 1'b0;
      end else begin
        @(negedge clk);
      end
      cyc++;
    end
    check("ign_lat", 16'(cyc), 16'(exp_lat(16'd6)));
    check("ign_res", result, 16'h002A);
    start = 1'b1; a_in = 16'd3; b_in = 16'd4;
    @(negedge clk);
    start = 1'b0;
    check("restart_busy", {15'd0, busy}, 16'h0001);
    cyc = 0;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check("restart_res", result, 16'h000C);
    @(negedge clk);

    // Asynchronous reset in the middle of a run.
    start = 1'b1; a_in = 16'h0055; b_in = 16'h00FF;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("mrst_busy", {15'd0, busy}, 16'h0000);
    check("mrst_done", {15'd0, done}, 16'h0000);
    check("mrst_result", result, 16'h0000);
    check("mrst_aluB", alu_b, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_mult("2x9", 16'h0002, 16'h0009, 16'h0012, exp_lat(16'h0009));

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
